gs_div_seq: RTL and testbench

Sequencer for the iterative Goldschmidt divider datapath. It time-shares one pipelined 19-bit multiplier between the numerator and denominator updates. It schedules the register write enables, including the K register, which loads the output of the 19-bit complement chain (K = 2 − D). It also provides a start/ready/done handshake to the surrounding FP divide unit. The block holds only control state; all data registers, operand muxes, the multiplier and the complement chain live in the datapath.

---
 rtl/gs_pkg.sv | 22 ++
 rtl/gs_div_seq_if.sv | 33 +++
 rtl/gs_phase_cnt.sv | 37 +++
 rtl/gs_div_seq.sv | 125 ++++++++++++
 tb/tb_gs_div_seq.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gs_pkg.sv
// Shared definitions for the Goldschmidt divider sequencer.
// Holds the datapath width, the FSM state encoding and the multiplier
// operand-A select encodings.
package gs_pkg;

  // Width of the mantissa datapath the sequencer drives (multiplier, N/D/K).
  localparam int GS_WIDTH = 19;

  // Sequencer states. ROUND is only reachable when GS_ROUND_EN is defined.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    RUN   = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } gs_state_e;

  // Multiplier operand A select; operand B is always the K register.
  localparam logic GS_SEL_N = 1'b0;
  localparam logic GS_SEL_D = 1'b1;

endpackage

// File: rtl/gs_div_seq_if.sv
// Handshake and datapath-control bundle between the FP divide unit /
// Goldschmidt datapath (master) and the sequencer (slave).
interface gs_div_seq_if #(
  parameter int ITERS = 3
);
  localparam int IW = $clog2(ITERS + 1);

  logic          start;
  logic          flush;
  logic          ready;
  logic          done;
  logic          ld_init;
  logic          mul_start;
  logic          mul_a_sel;
  logic          d_we;
  logic          n_we;
  logic          k_we;
  logic          rnd_we;
  logic [IW-1:0] iter;

  modport master (
    output start, flush,
    input  ready, done, ld_init, mul_start, mul_a_sel,
           d_we, n_we, k_we, rnd_we, iter
  );

  modport slave (
    input  start, flush,
    output ready, done, ld_init, mul_start, mul_a_sel,
           d_we, n_we, k_we, rnd_we, iter
  );

endinterface

// File: rtl/gs_phase_cnt.sv
// Per-iteration phase counter: counts 0..MUL_LAT+1 while enabled, wraps to 0
// after the terminal phase, and clears synchronously on clr_i.
module gs_phase_cnt #(
  parameter int MUL_LAT = 2,
  parameter int PW      = $clog2(MUL_LAT + 2)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [PW-1:0] ph_o,
  output logic          term_o
);

  localparam logic [PW-1:0] PH_LAST = PW'(MUL_LAT + 1);

  logic [PW-1:0] ph_q, ph_d;

  // Next phase: clear wins, otherwise advance and wrap at the terminal phase.
  always_comb begin
    ph_d = ph_q;
    if (clr_i)
      ph_d = '0;
    else if (en_i)
      ph_d = (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
  end

  // Phase register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ph_q <= '0;
    else        ph_q <= ph_d;
  end

  assign ph_o   = ph_q;
  assign term_o = (ph_q == PH_LAST);

endmodule

// File: rtl/gs_div_seq.sv
// Goldschmidt divider sequencer. Time-shares one pipelined multiplier between
// the D*K and N*K updates, schedules the N/D/K register write enables and
// provides the start/ready/done handshake. Control state only.
// Optional feature macro: GS_ROUND_EN inserts a one-cycle ROUND state that
// pulses rnd_we before done.
module gs_div_seq
  import gs_pkg::*;
#(
  parameter int ITERS   = 3,
  parameter int MUL_LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  gs_div_seq_if.slave  bus
);

  localparam int IW = $clog2(ITERS + 1);
  localparam int PW = $clog2(MUL_LAT + 2);

  localparam logic [IW-1:0] IT_LAST = IW'(ITERS - 1);
  localparam logic [PW-1:0] PH_ISS0 = PW'(0);
  localparam logic [PW-1:0] PH_ISS1 = PW'(1);
  localparam logic [PW-1:0] PH_DWE  = PW'(MUL_LAT);

  gs_state_e     state_q, state_d;
  logic [IW-1:0] iter_q, iter_d;
  logic [PW-1:0] ph;
  logic          ph_term;
  logic          last_it;
  logic          run_act;

  assign last_it = (iter_q == IT_LAST);

  // Phase only advances in RUN; any other state or an abort parks it at 0 so
  // each operation (and each restart after flush) begins at phase 0.
  gs_phase_cnt #(
    .MUL_LAT (MUL_LAT),
    .PW      (PW)
  ) u_ph (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  ((state_q != RUN) | bus.flush),
    .en_i   (state_q == RUN),
    .ph_o   (ph),
    .term_o (ph_term)
  );

  // Next-state and iteration bookkeeping; flush aborts from anywhere.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    if (bus.flush) begin
      state_d = IDLE;
      iter_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) state_d = INIT;
        end
        INIT: begin
          state_d = RUN;
          iter_d  = '0;
        end
        RUN: begin
          if (ph_term) begin
            if (last_it) begin
`ifdef GS_ROUND_EN
              state_d = ROUND;
`else
              state_d = DONE;
`endif
            end else begin
              iter_d = iter_q + 1'b1;
            end
          end
        end
        ROUND: begin
          state_d = DONE;
        end
        DONE: begin
          state_d = IDLE;
          iter_d  = '0;
        end
        default: begin
          state_d = IDLE;
          iter_d  = '0;
        end
      endcase
    end
  end

  // FSM state and iteration registers; reset lands directly in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  // Strobes decode registered state/phase only; flush is the sole
  // combinational input and only ever masks them off.
  assign run_act = (state_q == RUN) & ~bus.flush;

  assign bus.ready     = (state_q == IDLE);
  assign bus.ld_init   = (state_q == INIT) & ~bus.flush;
  assign bus.mul_start = run_act & ((ph == PH_ISS0) | (ph == PH_ISS1));
  // D*K is issued first so the new D is written one phase before the new N.
  assign bus.mul_a_sel = (run_act & (ph == PH_ISS0)) ? GS_SEL_D : GS_SEL_N;
  assign bus.d_we      = run_act & (ph == PH_DWE);
  assign bus.n_we      = run_act & ph_term;
  // The final iteration's K is never consumed, so it is not written.
  assign bus.k_we      = run_act & ph_term & ~last_it;
  assign bus.done      = (state_q == DONE) & ~bus.flush;
  assign bus.iter      = iter_q;

`ifdef GS_ROUND_EN
  assign bus.rnd_we    = (state_q == ROUND) & ~bus.flush;
`else
  assign bus.rnd_we    = 1'b0;
`endif

endmodule

// File: tb/tb_gs_div_seq.sv
// Scoreboard bench for gs_div_seq: two instances (ITERS=3/MUL_LAT=2 and
// ITERS=1/MUL_LAT=1). Stimulus pushes hand-computed strobe events and
// ready/iter probes; one monitor compares them at the falling edge.
module tb_gs_div_seq;

`ifdef GS_ROUND_EN
  localparam int RD = 1;
  localparam int NA = 15;
  localparam int NB = 6;
`else
  localparam int RD = 0;
  localparam int NA = 14;
  localparam int NB = 5;
`endif

  // Strobe vector bits: {ld_init, mul_start, mul_a_sel, d_we, n_we, k_we, rnd_we, done}
  localparam logic [7:0] LD = 8'h80;
  localparam logic [7:0] MS = 8'h40;
  localparam logic [7:0] AS = 8'h20;
  localparam logic [7:0] DW = 8'h10;
  localparam logic [7:0] NW = 8'h08;
  localparam logic [7:0] KW = 8'h04;
  localparam logic [7:0] RW = 8'h02;
  localparam logic [7:0] DN = 8'h01;

  // Default config (3 iterations, latency 2): offsets from the accept cycle.
`ifdef GS_ROUND_EN
  int         a_off [NA] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
  logic [7:0] a_vec [NA] = '{LD, MS|AS, MS, DW, NW|KW, MS|AS, MS, DW, NW|KW,
                             MS|AS, MS, DW, NW, RW, DN};
  int         b_off [NB] = '{1, 2, 3, 4, 5, 6};
  logic [7:0] b_vec [NB] = '{LD, MS|AS, MS|DW, NW, RW, DN};
`else
  int         a_off [NA] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14};
  logic [7:0] a_vec [NA] = '{LD, MS|AS, MS, DW, NW|KW, MS|AS, MS, DW, NW|KW,
                             MS|AS, MS, DW, NW, DN};
  int         b_off [NB] = '{1, 2, 3, 4, 5};
  logic [7:0] b_vec [NB] = '{LD, MS|AS, MS|DW, NW, DN};
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  logic fin = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gs_div_seq_if #(.ITERS(3)) ba ();
  gs_div_seq_if #(.ITERS(1)) bb ();

  gs_div_seq #(.ITERS(3), .MUL_LAT(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ba));
  gs_div_seq #(.ITERS(1), .MUL_LAT(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bb));

  logic [7:0] va, vb;
  assign va = {ba.ld_init, ba.mul_start, ba.mul_a_sel, ba.d_we, ba.n_we, ba.k_we, ba.rnd_we, ba.done};
  assign vb = {bb.ld_init, bb.mul_start, bb.mul_a_sel, bb.d_we, bb.n_we, bb.k_we, bb.rnd_we, bb.done};

  // Expected strobe events per instance and ready/iter probes.
  int         qa_cyc[$], qb_cyc[$];
  logic [7:0] qa_vec[$], qb_vec[$];
  int         pr_cyc[$], pr_dut[$], pr_it[$];
  logic       pr_rdy[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input int t0, input int upto);
    for (int i = 0; i < NA; i++)
      if (a_off[i] < upto) begin
        qa_cyc.push_back(t0 + a_off[i]);
        qa_vec.push_back(a_vec[i]);
      end
  endtask

  task automatic push_b(input int t0);
    for (int i = 0; i < NB; i++) begin
      qb_cyc.push_back(t0 + b_off[i]);
      qb_vec.push_back(b_vec[i]);
    end
  endtask

  task automatic probe(input int c, input int d, input logic r, input int it);
    pr_cyc.push_back(c);
    pr_dut.push_back(d);
    pr_rdy.push_back(r);
    pr_it.push_back(it);
  endtask

  // Monitor: every non-zero strobe vector must match the next expected event.
  int         ec, pd, pit, ait;
  logic [7:0] ev;
  logic       prd, ard;
  always @(negedge clk) begin
    if (va != 8'h00) begin
      n_tests++;
      if (qa_cyc.size() == 0) begin
        n_fail++;
        $display("FAIL evA unexpected cyc=%0d got=%02h want=none", cyc, va);
      end else begin
        ec = qa_cyc.pop_front();
        ev = qa_vec.pop_front();
        if (ec != cyc || ev != va) begin
          n_fail++;
          $display("FAIL evA cyc=%0d got=%02h want cyc=%0d vec=%02h", cyc, va, ec, ev);
        end
      end
    end
    if (vb != 8'h00) begin
      n_tests++;
      if (qb_cyc.size() == 0) begin
        n_fail++;
        $display("FAIL evB unexpected cyc=%0d got=%02h want=none", cyc, vb);
      end else begin
        ec = qb_cyc.pop_front();
        ev = qb_vec.pop_front();
        if (ec != cyc || ev != vb) begin
          n_fail++;
          $display("FAIL evB cyc=%0d got=%02h want cyc=%0d vec=%02h", cyc, vb, ec, ev);
        end
      end
    end
    while (pr_cyc.size() > 0 && pr_cyc[0] == cyc) begin
      void'(pr_cyc.pop_front());
      pd  = pr_dut.pop_front();
      prd = pr_rdy.pop_front();
      pit = pr_it.pop_front();
      ard = (pd == 0) ? ba.ready : bb.ready;
      ait = (pd == 0) ? int'(ba.iter) : int'(bb.iter);
      n_tests++;
      if (ard != prd || ait != pit) begin
        n_fail++;
        $display("FAIL probe%0d cyc=%0d got ready=%0b iter=%0d want ready=%0b iter=%0d",
                 pd, cyc, ard, ait, prd, pit);
      end
    end
    if (fin) begin
      n_tests++;
      if (qa_cyc.size() != 0 || qb_cyc.size() != 0 || pr_cyc.size() != 0) begin
        n_fail++;
        $display("FAIL leftover got evA=%0d evB=%0d probes=%0d want 0",
                 qa_cyc.size(), qb_cyc.size(), pr_cyc.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  // Stimulus.
  int t0;
  initial begin
    ba.start = 1'b0; ba.flush = 1'b0;
    bb.start = 1'b0; bb.flush = 1'b0;
    rst_n = 1'b0;
    tick();
    // Reset values.
    probe(cyc, 0, 1'b1, 0);
    probe(cyc, 1, 1'b1, 0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Default config, single operation.
    t0 = cyc;
    ba.start = 1'b1;
    push_a(t0, 100);
    probe(t0 + 6, 0, 1'b0, 1);
    probe(t0 + 10, 0, 1'b0, 2);
    probe(t0 + 14 + RD, 0, 1'b0, 2);
    probe(t0 + 15 + RD, 0, 1'b1, 0);
    tick();
    ba.start = 1'b0;
    repeat (17 + RD) tick();

    // ITERS=1, MUL_LAT=1.
    t0 = cyc;
    bb.start = 1'b1;
    push_b(t0);
    probe(t0 + 5 + RD, 1, 1'b0, 0);
    probe(t0 + 6 + RD, 1, 1'b1, 0);
    tick();
    bb.start = 1'b0;
    repeat (8 + RD) tick();

    // Flush at cycle 7, restart at cycle 8.
    t0 = cyc;
    ba.start = 1'b1;
    push_a(t0, 7);
    tick();
    ba.start = 1'b0;
    repeat (6) tick();
    ba.flush = 1'b1;
    probe(t0 + 7, 0, 1'b0, 1);
    tick();
    ba.flush = 1'b0;
    probe(t0 + 8, 0, 1'b1, 0);
    ba.start = 1'b1;
    push_a(t0 + 8, 100);
    probe(t0 + 23 + RD, 0, 1'b1, 0);
    tick();
    ba.start = 1'b0;
    repeat (17 + RD) tick();

    // start held high: second op accepted the cycle ready returns.
    t0 = cyc;
    ba.start = 1'b1;
    push_a(t0, 100);
    push_a(t0 + 15 + RD, 100);
    probe(t0 + 8, 0, 1'b0, 1);
    probe(t0 + 15 + RD, 0, 1'b1, 0);
    probe(t0 + 16 + RD, 0, 1'b0, 0);
    probe(t0 + 30 + 2 * RD, 0, 1'b1, 0);
    repeat (16 + RD) tick();
    ba.start = 1'b0;
    repeat (17 + RD) tick();

    // Asynchronous reset mid-RUN at cycle 6, between clock edges.
    t0 = cyc;
    ba.start = 1'b1;
    push_a(t0, 6);
    tick();
    ba.start = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    probe(t0 + 6, 0, 1'b1, 0);
    probe(t0 + 7, 0, 1'b1, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    probe(t0 + 10, 0, 1'b1, 0);
    probe(t0 + 13, 0, 1'b1, 0);
    repeat (8) tick();

    fin = 1'b1;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
